req_latch4: RTL and testbench

Four-channel request capture stage sitting directly upstream of the team's 4-to-2 priority encoder (y3 highest priority, y0 lowest). It synchronizes four asynchronous request lines, debounces each, turns each debounced rising edge into a sticky pending bit, and presents the pending bits as y3..y0 to the encoder. The consumer retires requests one at a time with a single-cycle ack, which clears the highest-priority pending bit.

---
 rtl/req_latch4_pkg.sv | 41 ++++
 rtl/req_latch4_if.sv | 21 ++
 rtl/req_debounce_ch.sv | 48 ++++
 rtl/req_latch4.sv | 64 ++++++
 tb/tb_req_latch4.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/req_latch4_pkg.sv
// Shared definitions for the request capture stage and the downstream priority encoder.
package req_latch4_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef logic [NUM_CH-1:0] ch_vec_t;

  typedef enum logic [1:0] {
    CH0 = 2'd0,
    CH1 = 2'd1,
    CH2 = 2'd2,
    CH3 = 2'd3
  } ch_id_t;

  // Highest index wins; the encoder walks the same table.
  localparam ch_id_t PRIO_ORDER [NUM_CH] = '{CH3, CH2, CH1, CH0};

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic ch_vec_t highest_onehot(input ch_vec_t v);
    ch_vec_t r;
    logic    found;
    r     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!found && v[PRIO_ORDER[k]]) begin
        r[PRIO_ORDER[k]] = 1'b1;
        found            = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/req_latch4_if.sv
// Request/retire bundle between the request sources, the capture stage and its consumer.
interface req_latch4_if;
  logic [req_latch4_pkg::NUM_CH-1:0] req_in;
  logic                              ack;
  logic                              y3;
  logic                              y2;
  logic                              y1;
  logic                              y0;
  logic                              valid;
  logic [req_latch4_pkg::NUM_CH-1:0] overrun;

  modport master (
    output req_in, ack,
    input  y3, y2, y1, y0, valid, overrun
  );

  modport slave (
    input  req_in, ack,
    output y3, y2, y1, y0, valid, overrun
  );
endinterface

// File: rtl/req_debounce_ch.sv
// One request channel: 2-flop synchronizer, level debouncer, and a one-cycle pulse
// on each accepted debounced rising transition.
module req_debounce_ch
  import req_latch4_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_async,
  output logic rise
);

  localparam int unsigned CW = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          deb;
  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= req_async;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (at_last) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Fires on the same edge that deb takes the new high level.
  assign rise = s2 & ~deb & at_last;

endmodule

// File: rtl/req_latch4.sv
// Four-channel request capture: debounced rising edges become sticky pending bits,
// retired highest-index-first by a single-cycle ack.
module req_latch4
  import req_latch4_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  req_latch4_if.slave  bus
);

  ch_vec_t rise;
  ch_vec_t pending;
  ch_vec_t overrun_q;
  ch_vec_t clr;
  ch_vec_t pending_next;
  ch_vec_t overrun_next;
  logic    any_pending;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    req_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_async (bus.req_in[i]),
      .rise      (rise[i])
    );
  end

  assign any_pending = |pending;

  // A retire clear beats a concurrent overrun set; a new rise beats a retire clear.
  always_comb begin
    clr          = '0;
    pending_next = pending;
    overrun_next = overrun_q;
    if (bus.ack && any_pending) clr = highest_onehot(pending);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (clr[i])                      overrun_next[i] = 1'b0;
      else if (rise[i] && pending[i])  overrun_next[i] = 1'b1;
    end
    pending_next = (pending & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      overrun_q <= '0;
    end else begin
      pending   <= pending_next;
      overrun_q <= overrun_next;
    end
  end

  assign bus.y3      = pending[3];
  assign bus.y2      = pending[2];
  assign bus.y1      = pending[1];
  assign bus.y0      = pending[0];
  assign bus.valid   = any_pending;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_req_latch4.sv
// Scoreboard bench for req_latch4: a window-based reference model predicts every
// cycle's outputs; a monitor compares them after each rising edge.
module tb_req_latch4;
  import req_latch4_pkg::*;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  req_latch4_if bus_if();

  req_latch4 #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit          done    = 0;
  logic [8:0]  exp_q[$];

  // Reference model state: synchronizer image, accepted level, sample history.
  logic [3:0]   s1_m, s2_m, deb_m, pend_m, ovr_m;
  logic [255:0] hist_m [4];

  function automatic logic [8:0] dut_out();
    return {bus_if.y3, bus_if.y2, bus_if.y1, bus_if.y0, bus_if.valid, bus_if.overrun};
  endfunction

  function automatic logic [3:0] yv();
    return {bus_if.y3, bus_if.y2, bus_if.y1, bus_if.y0};
  endfunction

  // Level flips once D consecutive synchronized samples all disagree with it.
  function automatic bit win_flip(input int c, input logic s2v);
    if (s2v == deb_m[c]) return 1'b0;
    for (int k = 0; k < int'(D) - 1; k++)
      if (hist_m[c][k] == deb_m[c]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit predict_rise(input int c);
    return win_flip(c, s2_m[c]) && s2_m[c];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [3:0] rise;
    logic [3:0] clr;
    rise = '0;
    clr  = '0;
    if (!rst_n) begin
      s1_m = '0; s2_m = '0; deb_m = '0; pend_m = '0; ovr_m = '0;
      for (int c = 0; c < 4; c++) hist_m[c] = '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (win_flip(c, s2_m[c])) begin
          deb_m[c] = ~deb_m[c];
          rise[c]  = deb_m[c];
        end
        hist_m[c] = {hist_m[c][254:0], s2_m[c]};
      end
      s2_m = s1_m;
      s1_m = bus_if.req_in;
      if (bus_if.ack && pend_m != 0) begin
        for (int c = 3; c >= 0; c--) begin
          if (pend_m[c]) begin
            clr[c] = 1'b1;
            break;
          end
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (clr[c])                    ovr_m[c] = 1'b0;
        else if (rise[c] && pend_m[c]) ovr_m[c] = 1'b1;
      end
      pend_m = (pend_m & ~clr) | rise;
    end
    exp_q.push_back({pend_m, |pend_m, ovr_m});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wait_bit(input int c, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (yv()[c]) begin
        seen = 1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Monitor: pops one expectation per rising edge.
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: got no expectation required one at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_outputs", 32'(dut_out()), 32'(e));
      end
    end
  end

  initial begin
    bit found;
    rst_n         = 1'b1;
    bus_if.req_in = '0;
    bus_if.ack    = 1'b0;
    s1_m = '0; s2_m = '0; deb_m = '0; pend_m = '0; ovr_m = '0;
    for (int c = 0; c < 4; c++) hist_m[c] = '0;
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", 32'(dut_out()), 32'd0);
    tick();
    tick();

    // Single request on channel 2, then retire.
    rst_n            = 1'b1;
    bus_if.req_in[2] = 1'b1;
    repeat (5) tick();
    check("latency_y2_low_edge5", 32'(bus_if.y2), 32'd0);
    tick();
    check("latency_y2_edge6", 32'({yv(), bus_if.valid}), 32'b0100_1);
    tick();
    bus_if.ack = 1'b1;
    tick();
    bus_if.ack = 1'b0;
    check("retire_y2", 32'({yv(), bus_if.valid}), 32'd0);
    bus_if.req_in = '0;
    repeat (8) tick();

    // Short pulse on channel 0.
    bus_if.req_in[0] = 1'b1;
    repeat (3) tick();
    bus_if.req_in[0] = 1'b0;
    repeat (10) tick();
    check("glitch_rejected", 32'({bus_if.y0, bus_if.overrun}), 32'd0);

    // Simultaneous capture, then priority-ordered retire.
    bus_if.req_in = 4'b1011;
    wait_bit(0, "prio_capture_timeout");
    check("prio_capture", 32'(yv()), 32'b1011);
    bus_if.ack = 1'b1;
    tick();
    check("prio_retire_1", 32'(yv()), 32'b0011);
    tick();
    check("prio_retire_2", 32'(yv()), 32'b0001);
    tick();
    check("prio_retire_3", 32'({yv(), bus_if.valid}), 32'd0);
    bus_if.ack    = 1'b0;
    bus_if.req_in = '0;
    repeat (10) tick();

    // New rise on channel 3 landing on the same edge as its retire.
    bus_if.req_in = 4'b1000;
    wait_bit(3, "setclr_first_timeout");
    bus_if.req_in = '0;
    repeat (8) tick();
    bus_if.req_in = 4'b1000;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (predict_rise(3)) begin
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        check("setclr_y3_stays", 32'(bus_if.y3), 32'd1);
        check("setclr_no_overrun", 32'(bus_if.overrun[3]), 32'd0);
        found = 1;
        break;
      end
      tick();
    end
    check("setclr_reached", 32'(found), 32'd1);
    bus_if.ack = 1'b1;
    tick();
    bus_if.ack    = 1'b0;
    bus_if.req_in = '0;
    repeat (10) tick();

    // Overrun on channel 1.
    bus_if.req_in = 4'b0010;
    wait_bit(1, "overrun_first_timeout");
    bus_if.req_in = '0;
    repeat (8) tick();
    bus_if.req_in = 4'b0010;
    repeat (10) tick();
    check("overrun_set", 32'({bus_if.y1, bus_if.overrun}), 32'h12);
    bus_if.ack = 1'b1;
    tick();
    bus_if.ack = 1'b0;
    check("overrun_cleared", 32'({bus_if.y1, bus_if.overrun}), 32'd0);
    bus_if.req_in = '0;
    repeat (10) tick();

    // Reset in the middle of a debounce window.
    bus_if.req_in = 4'b0100;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < int'(D) + 1; i++) begin
      tick();
      check("rstmid_y2_low", 32'(bus_if.y2), 32'd0);
    end
    tick();
    check("rstmid_y2_high", 32'(bus_if.y2), 32'd1);
    bus_if.ack = 1'b1;
    tick();
    check("rstmid_retire", 32'(dut_out()), 32'd0);
    tick();
    check("ack_idle_ignored", 32'(dut_out()), 32'd0);
    bus_if.ack    = 1'b0;
    bus_if.req_in = '0;
    repeat (8) tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(7) == 0) bus_if.req_in[c] = ~bus_if.req_in[c];
      bus_if.ack = ($urandom_range(4) == 0);
      rst_n      = ($urandom_range(399) != 0);
      tick();
    end
    rst_n      = 1'b1;
    bus_if.ack = 1'b0;

    done = 1;
    #20;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
